ms1004_spi_responder: RTL and testbench

Synthesizable MS1004 TDC emulator: the SPI slave that answers the TDC measurement controller's command sequence (power-on reset, configuration write, init, status read, result read) and drives the TDC interrupt line. It sits in the hardware-in-the-loop and simulation build in place of the physical MS1004. It runs on the controller's 50 MHz system clock and oversamples the SPI pins. Hit times come from a stimulus port, so the measurement path can be exercised without the analog front end.

---
 rtl/ms1004_spi_responder.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_ms1004_spi_responder.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ms1004_spi_responder.sv
// ---------------------------------------------------------------------------
// ms1004_spi_responder
//
// Emulates the MS1004 TDC as seen from the measurement controller. It answers
// the SPI command set (POR, config write, init, result read, status read) and
// drives the active-low TDC interrupt. Hit times come from a stimulus port.
// The SPI pins are oversampled on the 50 MHz system clock.
//
// Ports:
//   i_clk_50m      system clock, all logic on its rising edge
//   i_rst_n        synchronous active-low reset
//   i_spi_clk      SPI clock (mode 1), asynchronous
//   i_spi_ssn      SPI slave select, active-low, asynchronous
//   i_spi_mosi     master-to-slave data, asynchronous
//   o_spi_miso     slave-to-master data
//   o_tdc_intn     active-low interrupt: result or timeout available
//   i_hit_valid    one-cycle stop-event strobe
//   i_hit_data     measured time for that hit
//   o_cfg_reg0..3  configuration register bank
//   o_por_pulse    one-cycle strobe on a decoded 0x50
//   o_init_pulse   one-cycle strobe on a decoded 0x70
//   o_cmd_err      one-cycle strobe on an undecodable opcode
// ---------------------------------------------------------------------------
module ms1004_spi_responder #(
   parameter int          P_TIMEOUT = 4000,
   parameter logic [31:0] P_CFG_RST = 32'h0000_0000
) (
   input  logic        i_clk_50m,
   input  logic        i_rst_n,
   input  logic        i_spi_clk,
   input  logic        i_spi_ssn,
   input  logic        i_spi_mosi,
   output logic        o_spi_miso,
   output logic        o_tdc_intn,
   input  logic        i_hit_valid,
   input  logic [15:0] i_hit_data,
   output logic [31:0] o_cfg_reg0,
   output logic [31:0] o_cfg_reg1,
   output logic [31:0] o_cfg_reg2,
   output logic [31:0] o_cfg_reg3,
   output logic        o_por_pulse,
   output logic        o_init_pulse,
   output logic        o_cmd_err
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_OPCODE,
      ST_WRDATA,
      ST_RDDATA,
      ST_DISCARD
   } state_t;

   localparam int TMO_W = (P_TIMEOUT > 1) ? $clog2(P_TIMEOUT) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(P_TIMEOUT - 1);

   state_t             state_q, state_nxt;
   logic               sck_s1, sck_s2, sck_d, sck_rise_q, sck_fall_q;
   logic               ssn_s1, ssn_s2, ssn_d, ssn_rise_q, ssn_fall_q;
   logic               mosi_s1, mosi_s2;
   logic [4:0]         bit_cnt_q;
   logic [31:0]        rx_shift_q;
   logic [31:0]        rx_word;
   logic [7:0]         rx_byte;
   logic [31:0]        rd_shift_q;
   logic [1:0]         wr_idx_q;
   logic [31:0]        cfg_q [4];
   logic               armed_q, timeout_q;
   logic [15:0]        result_q;
   logic [3:0]         hit_cnt_q;
   logic [TMO_W-1:0]   tmo_cnt_q;
   logic [23:0]        status;
   logic               dec_por, dec_init, dec_wr, dec_rd_res, dec_rd_stat, dec_err;
   logic               wr_commit;

   assign rx_word = {rx_shift_q[30:0], mosi_s2};
   assign rx_byte = rx_word[7:0];
   assign status  = {14'd0, timeout_q, hit_cnt_q, 5'd0};

   assign o_cfg_reg0 = cfg_q[0];
   assign o_cfg_reg1 = cfg_q[1];
   assign o_cfg_reg2 = cfg_q[2];
   assign o_cfg_reg3 = cfg_q[3];

   // Two-stage synchronizers on all SPI pins followed by a registered edge
   // detector. SSN resets to "selected" so that a master still holding SSN
   // low across reset does not produce a fake falling edge; a mid-frame reset
   // therefore waits for a genuinely new frame.
   always_ff @(posedge i_clk_50m) begin
      if (!i_rst_n) begin
         sck_s1     <= 1'b0;
         sck_s2     <= 1'b0;
         sck_d      <= 1'b0;
         sck_rise_q <= 1'b0;
         sck_fall_q <= 1'b0;
         ssn_s1     <= 1'b0;
         ssn_s2     <= 1'b0;
         ssn_d      <= 1'b0;
         ssn_rise_q <= 1'b0;
         ssn_fall_q <= 1'b0;
         mosi_s1    <= 1'b0;
         mosi_s2    <= 1'b0;
      end else begin
         sck_s1     <= i_spi_clk;
         sck_s2     <= sck_s1;
         sck_d      <= sck_s2;
         sck_rise_q <= sck_s2 & ~sck_d;
         sck_fall_q <= ~sck_s2 & sck_d;
         ssn_s1     <= i_spi_ssn;
         ssn_s2     <= ssn_s1;
         ssn_d      <= ssn_s2;
         ssn_rise_q <= ssn_s2 & ~ssn_d;
         ssn_fall_q <= ~ssn_s2 & ssn_d;
         mosi_s1    <= i_spi_mosi;
         mosi_s2    <= mosi_s1;
      end
   end

   // Frame state register.
   always_ff @(posedge i_clk_50m) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Next-state logic and opcode decode. Decode happens in the cycle that the
   // 8th falling edge is seen, using the byte including the bit arriving now.
   // An SSN rise always ends the frame, which is what drops partial writes.
   always_comb begin
      state_nxt   = state_q;
      dec_por     = 1'b0;
      dec_init    = 1'b0;
      dec_wr      = 1'b0;
      dec_rd_res  = 1'b0;
      dec_rd_stat = 1'b0;
      dec_err     = 1'b0;
      wr_commit   = 1'b0;
      if (ssn_rise_q) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (ssn_fall_q) state_nxt = ST_OPCODE;
            end
            ST_OPCODE: begin
               if (sck_fall_q && bit_cnt_q == 5'd7) begin
                  if (rx_byte == 8'h50) begin
                     dec_por   = 1'b1;
                     state_nxt = ST_DISCARD;
                  end else if (rx_byte == 8'h70) begin
                     dec_init  = 1'b1;
                     state_nxt = ST_DISCARD;
                  end else if (rx_byte[7:2] == 6'b1000_00) begin
                     dec_wr    = 1'b1;
                     state_nxt = ST_WRDATA;
                  end else if (rx_byte == 8'hB0) begin
                     dec_rd_res = 1'b1;
                     state_nxt  = ST_RDDATA;
                  end else if (rx_byte == 8'hBD) begin
                     dec_rd_stat = 1'b1;
                     state_nxt   = ST_RDDATA;
                  end else begin
                     dec_err   = 1'b1;
                     state_nxt = ST_DISCARD;
                  end
               end
            end
            ST_WRDATA: begin
               if (sck_fall_q && bit_cnt_q == 5'd31) begin
                  wr_commit = 1'b1;
                  state_nxt = ST_DISCARD;
               end
            end
            default: ;
         endcase
      end
   end

   // Receive shifter and bit counter. The counter wraps to zero after the
   // opcode so the write phase counts 0..31; the shifter needs no clearing
   // because 32 fresh bits push out everything older.
   always_ff @(posedge i_clk_50m) begin
      if (!i_rst_n) begin
         bit_cnt_q  <= 5'd0;
         rx_shift_q <= 32'd0;
      end else if (state_q == ST_IDLE && ssn_fall_q) begin
         bit_cnt_q  <= 5'd0;
         rx_shift_q <= 32'd0;
      end else if (sck_fall_q && (state_q == ST_OPCODE || state_q == ST_WRDATA)) begin
         rx_shift_q <= rx_word;
         if (state_q == ST_OPCODE && bit_cnt_q == 5'd7) begin
            bit_cnt_q <= 5'd0;
         end else begin
            bit_cnt_q <= bit_cnt_q + 5'd1;
         end
      end
   end

   // Configuration bank: POR reloads every register, a completed write frame
   // updates the register whose index was latched from the opcode.
   always_ff @(posedge i_clk_50m) begin
      if (!i_rst_n || dec_por) begin
         for (int i = 0; i < 4; i++) cfg_q[i] <= P_CFG_RST;
         wr_idx_q <= 2'd0;
      end else begin
         if (dec_wr) wr_idx_q <= rx_byte[1:0];
         if (wr_commit) cfg_q[wr_idx_q] <= rx_word;
      end
   end

   // Read path. Each rising SCK edge in RDDATA presents the current MSB and
   // shifts left; zeros shift in, so MISO falls to 0 once all 32 bits are out.
   always_ff @(posedge i_clk_50m) begin
      if (!i_rst_n) begin
         rd_shift_q <= 32'd0;
         o_spi_miso <= 1'b0;
      end else begin
         if (dec_rd_res) begin
            rd_shift_q <= {7'd0, result_q, 9'd0};
         end else if (dec_rd_stat) begin
            rd_shift_q <= {status, 8'h00};
         end else if (state_q == ST_RDDATA && sck_rise_q) begin
            rd_shift_q <= {rd_shift_q[30:0], 1'b0};
         end
         if (state_q != ST_RDDATA) begin
            o_spi_miso <= 1'b0;
         end else if (sck_rise_q) begin
            o_spi_miso <= rd_shift_q[31];
         end
      end
   end

   // Measurement emulation. Priority order encodes the tie rules: POR/init
   // decodes beat a hit in the same cycle, and a hit beats timeout expiry.
   always_ff @(posedge i_clk_50m) begin
      if (!i_rst_n) begin
         o_por_pulse  <= 1'b0;
         o_init_pulse <= 1'b0;
         o_cmd_err    <= 1'b0;
         armed_q      <= 1'b0;
         timeout_q    <= 1'b0;
         result_q     <= 16'd0;
         hit_cnt_q    <= 4'd0;
         tmo_cnt_q    <= '0;
         o_tdc_intn   <= 1'b1;
      end else begin
         o_por_pulse  <= dec_por;
         o_init_pulse <= dec_init;
         o_cmd_err    <= dec_err;
         if (dec_por) begin
            armed_q    <= 1'b0;
            timeout_q  <= 1'b0;
            result_q   <= 16'd0;
            hit_cnt_q  <= 4'd0;
            tmo_cnt_q  <= '0;
            o_tdc_intn <= 1'b1;
         end else if (dec_init) begin
            armed_q    <= 1'b1;
            timeout_q  <= 1'b0;
            result_q   <= 16'd0;
            hit_cnt_q  <= 4'd0;
            tmo_cnt_q  <= '0;
            o_tdc_intn <= 1'b1;
         end else if (armed_q && i_hit_valid) begin
            armed_q    <= 1'b0;
            result_q   <= i_hit_data;
            o_tdc_intn <= 1'b0;
            if (hit_cnt_q != 4'hF) hit_cnt_q <= hit_cnt_q + 4'd1;
         end else if (armed_q) begin
            if (tmo_cnt_q == TMO_LAST) begin
               armed_q    <= 1'b0;
               timeout_q  <= 1'b1;
               o_tdc_intn <= 1'b0;
            end else begin
               tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ms1004_spi_responder.sv
// ---------------------------------------------------------------------------
// tb_ms1004_spi_responder
//
// Drives SPI mode-1 frames into ms1004_spi_responder and compares register
// contents, read data, strobes and the interrupt line with a small
// transaction-level model of the emulated TDC.
// ---------------------------------------------------------------------------
module tb_ms1004_spi_responder;

   logic        i_clk_50m   = 1'b0;
   logic        i_rst_n     = 1'b0;
   logic        i_spi_clk   = 1'b0;
   logic        i_spi_ssn   = 1'b1;
   logic        i_spi_mosi  = 1'b0;
   logic        i_hit_valid = 1'b0;
   logic [15:0] i_hit_data  = 16'd0;
   logic        o_spi_miso, o_tdc_intn, o_por_pulse, o_init_pulse, o_cmd_err;
   logic [31:0] o_cfg_reg0, o_cfg_reg1, o_cfg_reg2, o_cfg_reg3;
   logic [31:0] dut_cfg [4];

   int checks = 0;
   int errors = 0;

   // Strobe monitor: counts pulses, flags any strobe held two cycles, and
   // measures the cycles elapsed since the last init strobe.
   int   por_seen = 0, init_seen = 0, err_seen = 0, wide_seen = 0, since_init = 0;
   logic prev_por = 1'b0, prev_init = 1'b0, prev_err = 1'b0;

   // Transaction-level model of the TDC state.
   logic [31:0] m_cfg [4];
   logic        m_armed, m_timeout, m_intn;
   logic [15:0] m_result;
   int          m_hits;

   assign dut_cfg[0] = o_cfg_reg0;
   assign dut_cfg[1] = o_cfg_reg1;
   assign dut_cfg[2] = o_cfg_reg2;
   assign dut_cfg[3] = o_cfg_reg3;

   always #10 i_clk_50m = ~i_clk_50m;

   ms1004_spi_responder #(.P_TIMEOUT(4000), .P_CFG_RST(32'h0000_0000)) dut (
      .i_clk_50m   (i_clk_50m),
      .i_rst_n     (i_rst_n),
      .i_spi_clk   (i_spi_clk),
      .i_spi_ssn   (i_spi_ssn),
      .i_spi_mosi  (i_spi_mosi),
      .o_spi_miso  (o_spi_miso),
      .o_tdc_intn  (o_tdc_intn),
      .i_hit_valid (i_hit_valid),
      .i_hit_data  (i_hit_data),
      .o_cfg_reg0  (o_cfg_reg0),
      .o_cfg_reg1  (o_cfg_reg1),
      .o_cfg_reg2  (o_cfg_reg2),
      .o_cfg_reg3  (o_cfg_reg3),
      .o_por_pulse (o_por_pulse),
      .o_init_pulse(o_init_pulse),
      .o_cmd_err   (o_cmd_err)
   );

   // Strobe bookkeeping sampled on each system clock edge.
   always @(posedge i_clk_50m) begin
      if (o_por_pulse)  por_seen  <= por_seen + 1;
      if (o_init_pulse) init_seen <= init_seen + 1;
      if (o_cmd_err)    err_seen  <= err_seen + 1;
      if ((o_por_pulse && prev_por) || (o_init_pulse && prev_init) || (o_cmd_err && prev_err))
         wide_seen <= wide_seen + 1;
      prev_por  <= o_por_pulse;
      prev_init <= o_init_pulse;
      prev_err  <= o_cmd_err;
      if (o_init_pulse) since_init <= 0;
      else              since_init <= since_init + 1;
   end

   // ---------------- model ----------------
   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_cfg[i] = 32'h0000_0000;
      m_armed = 1'b0; m_timeout = 1'b0; m_result = 16'd0; m_hits = 0; m_intn = 1'b1;
   endtask

   task automatic model_init();
      m_armed = 1'b1; m_timeout = 1'b0; m_result = 16'd0; m_hits = 0; m_intn = 1'b1;
   endtask

   task automatic model_hit(input logic [15:0] d);
      if (m_armed) begin
         m_result = d;
         m_hits   = (m_hits < 15) ? m_hits + 1 : 15;
         m_armed  = 1'b0;
         m_intn   = 1'b0;
      end
   endtask

   task automatic model_timeout();
      if (m_armed) begin
         m_timeout = 1'b1; m_armed = 1'b0; m_intn = 1'b0;
      end
   endtask

   function automatic logic [31:0] exp_result();
      return 32'(m_result) * 32'd512;
   endfunction

   function automatic logic [31:0] exp_status();
      return (32'(m_timeout) << 17) | (32'(m_hits) << 13);
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge i_clk_50m);
   endtask

   task automatic spi_bit(input logic b, output logic so);
      i_spi_clk  = 1'b1;
      i_spi_mosi = b;
      tick(6);
      so = o_spi_miso;
      i_spi_clk = 1'b0;
      tick(6);
   endtask

   task automatic spi_xfer(input logic [7:0] op, input int nbits, input logic [31:0] wdata,
                           output logic [31:0] rdata);
      logic so;
      rdata = 32'd0;
      i_spi_ssn = 1'b0;
      tick(6);
      for (int i = 0; i < 8; i++) spi_bit(op[7-i], so);
      for (int i = 0; i < nbits; i++) begin
         spi_bit(wdata[31-i], so);
         rdata = {rdata[30:0], so};
      end
      tick(6);
      i_spi_ssn = 1'b1;
      tick(8);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic so;
      logic any_one;
      i_rst_n = 1'b0;
      tick(4);
      model_reset();
      checks++;
      if (o_tdc_intn !== 1'b1) begin errors++; $display("[TB] FAIL reset_intn: got %b expected 1", o_tdc_intn); end
      checks++;
      if (o_spi_miso !== 1'b0) begin errors++; $display("[TB] FAIL reset_miso: got %b expected 0", o_spi_miso); end
      i_rst_n = 1'b1;
      tick(4);
      any_one = 1'b0;
      i_spi_ssn = 1'b0;
      tick(6);
      for (int i = 0; i < 5; i++) begin
         spi_bit(1'b0, so);
         if (so !== 1'b0) any_one = 1'b1;
      end
      tick(6);
      i_spi_ssn = 1'b1;
      tick(8);
      checks++;
      if (any_one !== 1'b0) begin errors++; $display("[TB] FAIL sweep_miso: got %b expected 0", any_one); end
      checks++;
      if (por_seen + init_seen + err_seen != 0) begin
         errors++; $display("[TB] FAIL sweep_strobes: got %0d expected 0", por_seen + init_seen + err_seen);
      end
      checks++;
      if (o_tdc_intn !== 1'b1) begin errors++; $display("[TB] FAIL sweep_intn: got %b expected 1", o_tdc_intn); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (dut_cfg[i] !== m_cfg[i]) begin
            errors++; $display("[TB] FAIL reset_cfg%0d: got %h expected %h", i, dut_cfg[i], m_cfg[i]);
         end
      end
   endtask

   task automatic test_cfg_write();
      logic [31:0] rd, data;
      logic [1:0]  idx;
      int          nb;
      for (int k = 0; k < 12; k++) begin
         if (k == 0) begin
            idx = 2'd0; data = 32'h024A_2050; nb = 32;
         end else if (k == 1) begin
            idx = 2'd0; data = 32'hDEAD_BEEF; nb = 20;
         end else begin
            idx  = 2'($urandom_range(0, 3));
            data = $urandom;
            nb   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 31) : 32;
         end
         spi_xfer({6'b1000_00, idx}, nb, data, rd);
         if (nb == 32) m_cfg[idx] = data;
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (dut_cfg[i] !== m_cfg[i]) begin
               errors++;
               $display("[TB] FAIL cfg_write%0d_reg%0d (bits %0d): got %h expected %h", k, i, nb, dut_cfg[i], m_cfg[i]);
            end
         end
      end
   endtask

   task automatic test_hit_read();
      logic [31:0] rd;
      logic [15:0] data;
      int          init_before;
      data = 16'($urandom);
      i_hit_valid = 1'b1; i_hit_data = data; tick(1); i_hit_valid = 1'b0;
      model_hit(data);
      tick(2);
      checks++;
      if (o_tdc_intn !== m_intn) begin errors++; $display("[TB] FAIL disarmed_hit_intn: got %b expected %b", o_tdc_intn, m_intn); end
      for (int k = 0; k < 4; k++) begin
         data = (k == 0) ? 16'h1234 : 16'($urandom);
         init_before = init_seen;
         spi_xfer(8'h70, 0, 32'd0, rd);
         model_init();
         checks++;
         if (init_seen != init_before + 1) begin
            errors++; $display("[TB] FAIL init_strobe%0d: got %0d expected %0d", k, init_seen - init_before, 1);
         end
         tick($urandom_range(1, 20));
         checks++;
         if (o_tdc_intn !== 1'b1) begin errors++; $display("[TB] FAIL armed_intn%0d: got %b expected 1", k, o_tdc_intn); end
         i_hit_valid = 1'b1; i_hit_data = data; tick(1); i_hit_valid = 1'b0;
         model_hit(data);
         checks++;
         if (o_tdc_intn !== 1'b0) begin errors++; $display("[TB] FAIL hit_intn%0d: got %b expected 0", k, o_tdc_intn); end
         i_hit_valid = 1'b1; i_hit_data = ~data; tick(1); i_hit_valid = 1'b0;
         model_hit(~data);
         spi_xfer(8'hB0, 32, 32'd0, rd);
         checks++;
         if (rd !== exp_result()) begin errors++; $display("[TB] FAIL read_result%0d: got %h expected %h", k, rd, exp_result()); end
         spi_xfer(8'hBD, 8, 32'd0, rd);
         checks++;
         if (rd[7:0] !== exp_status() >> 24) begin
            errors++; $display("[TB] FAIL status_byte%0d: got %h expected %h", k, rd[7:0], exp_status() >> 24);
         end
         spi_xfer(8'hBD, 32, 32'd0, rd);
         checks++;
         if (rd !== exp_status()) begin errors++; $display("[TB] FAIL read_status%0d: got %h expected %h", k, rd, exp_status()); end
      end
   endtask

   task automatic test_timeout();
      logic [31:0] rd;
      logic [15:0] data;
      int          guard;
      for (int k = 0; k < 2; k++) begin
         data = 16'($urandom_range(1, 65535));
         spi_xfer(8'h70, 0, 32'd0, rd);
         model_init();
         guard = 0;
         while (since_init != 3998 && guard < 6000) begin
            tick(1);
            guard++;
         end
         checks++;
         if (guard >= 6000) begin errors++; $display("[TB] FAIL timeout_wait%0d: got %0d cycles expected <6000", k, guard); end
         checks++;
         if (o_tdc_intn !== 1'b1) begin errors++; $display("[TB] FAIL pre_expiry_intn%0d: got %b expected 1", k, o_tdc_intn); end
         if (k == 1) begin
            i_hit_valid = 1'b1; i_hit_data = data; tick(1); i_hit_valid = 1'b0;
            model_hit(data);
         end else begin
            tick(1);
         end
         model_timeout();
         checks++;
         if (o_tdc_intn !== 1'b0) begin errors++; $display("[TB] FAIL expiry_intn%0d: got %b expected 0", k, o_tdc_intn); end
         spi_xfer(8'hBD, 32, 32'd0, rd);
         checks++;
         if (rd !== exp_status()) begin errors++; $display("[TB] FAIL timeout_status%0d: got %h expected %h", k, rd, exp_status()); end
         i_hit_valid = 1'b1; i_hit_data = ~data; tick(1); i_hit_valid = 1'b0;
         model_hit(~data);
         spi_xfer(8'hB0, 32, 32'd0, rd);
         checks++;
         if (rd !== exp_result()) begin errors++; $display("[TB] FAIL timeout_result%0d: got %h expected %h", k, rd, exp_result()); end
      end
   endtask

   task automatic test_cmd_err();
      logic [31:0] rd, data;
      logic [7:0]  op;
      int          err_before, por_before;
      for (int k = 0; k < 4; k++) begin
         op = (k == 0) ? 8'h55 : 8'($urandom_range(0, 255));
         if (op == 8'h50 || op == 8'h70 || op[7:2] == 6'b1000_00 || op == 8'hB0 || op == 8'hBD) op = 8'h55;
         err_before = err_seen;
         spi_xfer(op, 32, $urandom, rd);
         checks++;
         if (err_seen != err_before + 1) begin
            errors++; $display("[TB] FAIL cmd_err_strobe_%h: got %0d expected 1", op, err_seen - err_before);
         end
         checks++;
         if (rd !== 32'd0) begin errors++; $display("[TB] FAIL cmd_err_miso_%h: got %h expected 0", op, rd); end
      end
      data = $urandom | 32'h1;
      spi_xfer(8'h82, 32, data, rd);
      m_cfg[2] = data;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (dut_cfg[i] !== m_cfg[i]) begin errors++; $display("[TB] FAIL pre_por_cfg%0d: got %h expected %h", i, dut_cfg[i], m_cfg[i]); end
      end
      por_before = por_seen;
      spi_xfer(8'h50, 0, 32'd0, rd);
      model_reset();
      checks++;
      if (por_seen != por_before + 1) begin errors++; $display("[TB] FAIL por_strobe: got %0d expected 1", por_seen - por_before); end
      checks++;
      if (o_tdc_intn !== 1'b1) begin errors++; $display("[TB] FAIL por_intn: got %b expected 1", o_tdc_intn); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (dut_cfg[i] !== m_cfg[i]) begin errors++; $display("[TB] FAIL por_cfg%0d: got %h expected %h", i, dut_cfg[i], m_cfg[i]); end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd;
      logic [15:0] d1, d2, d3;
      logic [7:0]  op;
      logic        so;
      d1 = 16'($urandom_range(1, 65535));
      d2 = 16'($urandom_range(1, 65535));
      d3 = 16'($urandom_range(1, 65535));
      spi_xfer(8'h70, 0, 32'd0, rd);
      model_init();
      i_hit_valid = 1'b1; i_hit_data = d1; tick(1); i_hit_valid = 1'b0;
      model_hit(d1);
      op = 8'h70;
      i_spi_ssn = 1'b0;
      tick(6);
      for (int i = 0; i < 7; i++) spi_bit(op[7-i], so);
      i_spi_clk = 1'b1; i_spi_mosi = op[0];
      tick(6);
      i_spi_clk = 1'b0;
      tick(3);
      i_hit_valid = 1'b1; i_hit_data = d2;
      tick(1);
      i_hit_valid = 1'b0;
      checks++;
      if (o_init_pulse !== 1'b1) begin errors++; $display("[TB] FAIL tie_alignment: got %b expected 1", o_init_pulse); end
      tick(5);
      i_spi_ssn = 1'b1;
      tick(8);
      model_init();
      checks++;
      if (o_tdc_intn !== 1'b1) begin errors++; $display("[TB] FAIL tie_intn: got %b expected 1", o_tdc_intn); end
      spi_xfer(8'hB0, 32, 32'd0, rd);
      checks++;
      if (rd !== exp_result()) begin errors++; $display("[TB] FAIL tie_result: got %h expected %h", rd, exp_result()); end
      i_hit_valid = 1'b1; i_hit_data = d3; tick(1); i_hit_valid = 1'b0;
      model_hit(d3);
      checks++;
      if (o_tdc_intn !== m_intn) begin errors++; $display("[TB] FAIL tie_armed_intn: got %b expected %b", o_tdc_intn, m_intn); end
      spi_xfer(8'hB0, 32, 32'd0, rd);
      checks++;
      if (rd !== exp_result()) begin errors++; $display("[TB] FAIL tie_rehit_result: got %h expected %h", rd, exp_result()); end
   endtask

   task automatic test_reset_mid_read();
      logic [31:0] rd, data, full;
      logic [15:0] d;
      logic [7:0]  op;
      logic [9:0]  part;
      logic        so, any_one;
      int          err_before;
      d = 16'($urandom_range(1, 65535));
      data = $urandom | 32'h8000_0000;
      spi_xfer(8'h70, 0, 32'd0, rd);
      model_init();
      i_hit_valid = 1'b1; i_hit_data = d; tick(1); i_hit_valid = 1'b0;
      model_hit(d);
      spi_xfer(8'h81, 32, data, rd);
      m_cfg[1] = data;
      full = exp_result();
      op = 8'hB0;
      part = 10'd0;
      i_spi_ssn = 1'b0;
      tick(6);
      for (int i = 0; i < 8; i++) spi_bit(op[7-i], so);
      for (int i = 0; i < 10; i++) begin
         spi_bit(1'b0, so);
         part = {part[8:0], so};
      end
      checks++;
      if (part !== full[31:22]) begin errors++; $display("[TB] FAIL partial_read: got %h expected %h", part, full[31:22]); end
      i_rst_n = 1'b0;
      tick(3);
      model_reset();
      checks++;
      if (o_spi_miso !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_miso: got %b expected 0", o_spi_miso); end
      i_rst_n = 1'b1;
      tick(2);
      err_before = err_seen;
      any_one = 1'b0;
      op = 8'h55;
      for (int i = 0; i < 16; i++) begin
         spi_bit(op[7 - (i % 8)], so);
         if (so !== 1'b0) any_one = 1'b1;
      end
      tick(6);
      i_spi_ssn = 1'b1;
      tick(8);
      checks++;
      if (any_one !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_miso: got %b expected 0", any_one); end
      checks++;
      if (err_seen != err_before) begin errors++; $display("[TB] FAIL post_reset_decode: got %0d expected 0", err_seen - err_before); end
      checks++;
      if (o_tdc_intn !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_intn: got %b expected 1", o_tdc_intn); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (dut_cfg[i] !== m_cfg[i]) begin errors++; $display("[TB] FAIL post_reset_cfg%0d: got %h expected %h", i, dut_cfg[i], m_cfg[i]); end
      end
      spi_xfer(8'hB0, 32, 32'd0, rd);
      checks++;
      if (rd !== exp_result()) begin errors++; $display("[TB] FAIL post_reset_result: got %h expected %h", rd, exp_result()); end
      spi_xfer(8'hBD, 32, 32'd0, rd);
      checks++;
      if (rd !== exp_status()) begin errors++; $display("[TB] FAIL post_reset_status: got %h expected %h", rd, exp_status()); end
   endtask

   // Scenario sequence; each task leaves the bus idle for the next one.
   initial begin
      model_reset();
      tick(2);
      test_reset();
      test_cfg_write();
      test_hit_read();
      test_timeout();
      test_cmd_err();
      test_back_to_back();
      test_reset_mid_read();
      checks++;
      if (wide_seen != 0) begin errors++; $display("[TB] FAIL strobe_width: got %0d wide pulses expected 0", wide_seen); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
